// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the RV32I decode/control stage: opcodes,
// control field encodings and the control bundle carried down the pipe.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
  } imm_sel_e;

  typedef enum logic [2:0] {
    SL_SB = 3'd0, SL_SH, SL_SW, SL_LB, SL_LH, SL_LW, SL_LBU, SL_LHU
  } slt_sl_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0, WB_LSU, WB_PC4
  } wb_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    alu_op_e     alu_op;
    imm_sel_e    imm_sel;
    slt_sl_e     slt_sl;
    wb_sel_e     wb_sel;
    logic        rd_wren;
    logic        mem_wren;
    logic        op_a_sel;
    logic        op_b_sel;
    logic        br_unsigned;
    logic        enb_branch;
    logic        enb_jump;
    logic [2:0]  br_funct3;
    logic        insn_vld;
    logic        illegal;
  } ctrl_bundle_t;

  // Base integer ALU op for an OP/OP-IMM funct3; alt selects SUB/SRA.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational RV32I(+M) decoder: instruction word to control bundle
// and illegal flag. PC, insn_vld and illegal bundle fields are left to the caller.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0]  i_instr,
  output ctrl_bundle_t o_bundle,
  output logic         o_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];

  always_comb begin
    o_bundle       = '0;
    o_bundle.instr = i_instr;
    o_illegal      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        o_bundle.alu_op   = ALU_PASSB;
        o_bundle.imm_sel  = IMM_U;
        o_bundle.op_b_sel = 1'b1;
        o_bundle.rd_wren  = 1'b1;
      end
      OPC_AUIPC: begin
        o_bundle.imm_sel  = IMM_U;
        o_bundle.op_a_sel = 1'b1;
        o_bundle.op_b_sel = 1'b1;
        o_bundle.rd_wren  = 1'b1;
      end
      OPC_JAL: begin
        o_bundle.imm_sel  = IMM_J;
        o_bundle.op_a_sel = 1'b1;
        o_bundle.op_b_sel = 1'b1;
        o_bundle.rd_wren  = 1'b1;
        o_bundle.wb_sel   = WB_PC4;
        o_bundle.enb_jump = 1'b1;
      end
      OPC_JALR: begin
        o_illegal         = (funct3 != 3'd0);
        o_bundle.imm_sel  = IMM_I;
        o_bundle.op_b_sel = 1'b1;
        o_bundle.rd_wren  = 1'b1;
        o_bundle.wb_sel   = WB_PC4;
        o_bundle.enb_jump = 1'b1;
      end
      OPC_BRANCH: begin
        // Target is computed as PC+imm here; the compare itself happens in EX.
        o_illegal            = (funct3 == 3'd2) || (funct3 == 3'd3);
        o_bundle.imm_sel     = IMM_B;
        o_bundle.op_a_sel    = 1'b1;
        o_bundle.op_b_sel    = 1'b1;
        o_bundle.enb_branch  = 1'b1;
        o_bundle.br_funct3   = funct3;
        o_bundle.br_unsigned = funct3[1];
      end
      OPC_LOAD: begin
        o_bundle.imm_sel  = IMM_I;
        o_bundle.op_b_sel = 1'b1;
        o_bundle.rd_wren  = 1'b1;
        o_bundle.wb_sel   = WB_LSU;
        case (funct3)
          3'd0:    o_bundle.slt_sl = SL_LB;
          3'd1:    o_bundle.slt_sl = SL_LH;
          3'd2:    o_bundle.slt_sl = SL_LW;
          3'd4:    o_bundle.slt_sl = SL_LBU;
          3'd5:    o_bundle.slt_sl = SL_LHU;
          default: o_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        o_bundle.imm_sel  = IMM_S;
        o_bundle.op_b_sel = 1'b1;
        o_bundle.mem_wren = 1'b1;
        if (funct3 > 3'd2) o_illegal = 1'b1;
        else               o_bundle.slt_sl = slt_sl_e'(funct3);
      end
      OPC_OPIMM: begin
        o_bundle.alu_op   = alu_from_funct3(funct3, (funct3 == 3'd5) && i_instr[30]);
        o_bundle.imm_sel  = IMM_I;
        o_bundle.op_b_sel = 1'b1;
        o_bundle.rd_wren  = 1'b1;
      end
      OPC_OP: begin
        o_bundle.rd_wren = 1'b1;
        if (funct7 == 7'h00)
          o_bundle.alu_op = alu_from_funct3(funct3, 1'b0);
        else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))
          o_bundle.alu_op = alu_from_funct3(funct3, 1'b1);
        else if (funct7 == 7'h01 && M_EXT)
          o_bundle.alu_op = alu_op_e'(5'd11 + {2'b00, funct3});
        else
          o_illegal = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) begin
      o_bundle.rd_wren    = 1'b0;
      o_bundle.mem_wren   = 1'b0;
      o_bundle.enb_branch = 1'b0;
      o_bundle.enb_jump   = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Pipelined decode/control stage: decodes the IF/ID instruction and registers
// the control bundle into ID/EX behind a main register plus one skid register.
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter bit M_EXT = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [31:0]      i_instr,
  input  logic [31:0]      i_pc,
  input  logic             i_flush,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [31:0]      o_instr,
  output logic [31:0]      o_pc,
  output logic [4:0]       o_alu_op,
  output logic [2:0]       o_imm_sel,
  output logic [2:0]       o_slt_sl,
  output logic [1:0]       o_wb_sel,
  output logic             o_rd_wren,
  output logic             o_mem_wren,
  output logic             o_op_a_sel,
  output logic             o_op_b_sel,
  output logic             o_br_unsigned,
  output logic             o_enb_branch,
  output logic             o_enb_jump,
  output logic [2:0]       o_br_funct3,
  output logic             o_insn_vld,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  ctrl_bundle_t dec_bundle, acc_bundle;
  ctrl_bundle_t main_q, main_d, skid_q, skid_d;
  logic         dec_illegal;
  logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         accept, main_free;

  ctrl_decode #(.M_EXT(M_EXT)) u_decode (
    .i_instr  (i_instr),
    .o_bundle (dec_bundle),
    .o_illegal(dec_illegal)
  );

  always_comb begin
    acc_bundle          = dec_bundle;
    acc_bundle.pc       = i_pc;
    acc_bundle.illegal  = dec_illegal;
    acc_bundle.insn_vld = ~dec_illegal;
  end

  // Ready only depends on skid occupancy, so an accept never meets a full skid.
  assign accept    = i_vld & ~skid_vld_q;
  assign main_free = ~main_vld_q | i_rdy;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (main_vld_q && i_rdy && main_q.illegal && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
    if (i_flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_free) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = acc_bundle;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = acc_bundle;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_rdy         = ~skid_vld_q;
  assign o_vld         = main_vld_q;
  assign o_instr       = main_q.instr;
  assign o_pc          = main_q.pc;
  assign o_alu_op      = main_q.alu_op;
  assign o_imm_sel     = main_q.imm_sel;
  assign o_slt_sl      = main_q.slt_sl;
  assign o_wb_sel      = main_q.wb_sel;
  assign o_rd_wren     = main_q.rd_wren;
  assign o_mem_wren    = main_q.mem_wren;
  assign o_op_a_sel    = main_q.op_a_sel;
  assign o_op_b_sel    = main_q.op_b_sel;
  assign o_br_unsigned = main_q.br_unsigned;
  assign o_enb_branch  = main_q.enb_branch;
  assign o_enb_jump    = main_q.enb_jump;
  assign o_br_funct3   = main_q.br_funct3;
  assign o_insn_vld    = main_q.insn_vld;
  assign o_illegal     = main_q.illegal;
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Testbench for decode_ctrl_stage: two instances (M_EXT=0/CNT_W=2 and
// M_EXT=1/CNT_W=8) share stimulus and are compared to a queue-based model.
module tb_decode_ctrl_stage;

  typedef struct packed {
    logic        vld, rdy;
    logic [31:0] instr, pc;
    logic [4:0]  alu;
    logic [2:0]  imm, sl;
    logic [1:0]  wb;
    logic        rdw, memw, asel, bsel, bru, enbb, enbj;
    logic [2:0]  bf3;
    logic        insnv, illegal;
    logic [7:0]  cnt;
  } obs_t;

  typedef struct packed {
    logic [4:0] alu;
    logic [2:0] imm, sl;
    logic [1:0] wb;
    logic       rdw, memw, asel, bsel, bru, enbb, enbj;
    logic [2:0] bf3;
    logic       illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN, iVld, iRdy, iFlush;
  logic [31:0] iInstr, iPc;

  logic        oRdy0, oVld0, rdWren0, memWren0, opASel0, opBSel0, brUns0, enbBr0, enbJmp0, insnVld0, illegal0;
  logic [31:0] oInstr0, oPc0;
  logic [4:0]  aluOp0;
  logic [2:0]  immSel0, sltSl0, brF3_0;
  logic [1:0]  wbSel0;
  logic [1:0]  cnt0;
  logic        oRdy1, oVld1, rdWren1, memWren1, opASel1, opBSel1, brUns1, enbBr1, enbJmp1, insnVld1, illegal1;
  logic [31:0] oInstr1, oPc1;
  logic [4:0]  aluOp1;
  logic [2:0]  immSel1, sltSl1, brF3_1;
  logic [1:0]  wbSel1;
  logic [7:0]  cnt1;

  obs_t        obs0, obs1;
  logic [63:0] pipeQ[$];
  int          expCnt0, expCnt1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.M_EXT(1'b0), .CNT_W(2)) dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_vld(iVld), .o_rdy(oRdy0), .i_instr(iInstr), .i_pc(iPc),
    .i_flush(iFlush), .o_vld(oVld0), .i_rdy(iRdy), .o_instr(oInstr0), .o_pc(oPc0),
    .o_alu_op(aluOp0), .o_imm_sel(immSel0), .o_slt_sl(sltSl0), .o_wb_sel(wbSel0),
    .o_rd_wren(rdWren0), .o_mem_wren(memWren0), .o_op_a_sel(opASel0), .o_op_b_sel(opBSel0),
    .o_br_unsigned(brUns0), .o_enb_branch(enbBr0), .o_enb_jump(enbJmp0), .o_br_funct3(brF3_0),
    .o_insn_vld(insnVld0), .o_illegal(illegal0), .o_illegal_cnt(cnt0)
  );

  decode_ctrl_stage #(.M_EXT(1'b1), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_vld(iVld), .o_rdy(oRdy1), .i_instr(iInstr), .i_pc(iPc),
    .i_flush(iFlush), .o_vld(oVld1), .i_rdy(iRdy), .o_instr(oInstr1), .o_pc(oPc1),
    .o_alu_op(aluOp1), .o_imm_sel(immSel1), .o_slt_sl(sltSl1), .o_wb_sel(wbSel1),
    .o_rd_wren(rdWren1), .o_mem_wren(memWren1), .o_op_a_sel(opASel1), .o_op_b_sel(opBSel1),
    .o_br_unsigned(brUns1), .o_enb_branch(enbBr1), .o_enb_jump(enbJmp1), .o_br_funct3(brF3_1),
    .o_insn_vld(insnVld1), .o_illegal(illegal1), .o_illegal_cnt(cnt1)
  );

  always_comb begin
    obs0 = '{vld: oVld0, rdy: oRdy0, instr: oInstr0, pc: oPc0, alu: aluOp0, imm: immSel0,
             sl: sltSl0, wb: wbSel0, rdw: rdWren0, memw: memWren0, asel: opASel0,
             bsel: opBSel0, bru: brUns0, enbb: enbBr0, enbj: enbJmp0, bf3: brF3_0,
             insnv: insnVld0, illegal: illegal0, cnt: {6'd0, cnt0}};
    obs1 = '{vld: oVld1, rdy: oRdy1, instr: oInstr1, pc: oPc1, alu: aluOp1, imm: immSel1,
             sl: sltSl1, wb: wbSel1, rdw: rdWren1, memw: memWren1, asel: opASel1,
             bsel: opBSel1, bru: brUns1, enbb: enbBr1, enbj: enbJmp1, bf3: brF3_1,
             insnv: insnVld1, illegal: illegal1, cnt: cnt1};
  end

  // Expected control fields written straight from the instruction-set rules.
  function automatic exp_t refDecode(input logic [31:0] ins, input bit mExt);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    logic [4:0] opTab [8];
    opTab = '{5'd0, 5'd7, 5'd2, 5'd3, 5'd4, 5'd8, 5'd5, 5'd6};
    e  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b1;
    case (ins[6:0])
      7'h37: begin e.alu = 5'd10; e.imm = 3'd5; e.bsel = 1; e.rdw = 1; end
      7'h17: begin e.imm = 3'd5; e.asel = 1; e.bsel = 1; e.rdw = 1; end
      7'h6F: begin e.imm = 3'd4; e.asel = 1; e.bsel = 1; e.rdw = 1; e.wb = 2'd2; e.enbj = 1; end
      7'h67: begin ok = (f3 == 3'd0); e.imm = 3'd1; e.bsel = 1; e.rdw = 1; e.wb = 2'd2; e.enbj = 1; end
      7'h63: begin
        ok = !(f3 == 3'd2 || f3 == 3'd3);
        e.imm = 3'd3; e.asel = 1; e.bsel = 1; e.enbb = 1; e.bf3 = f3; e.bru = (f3 >= 3'd6);
      end
      7'h03: begin
        ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        e.sl = (f3 < 3'd4) ? f3 + 3'd3 : f3 + 3'd2;
        e.imm = 3'd1; e.bsel = 1; e.rdw = 1; e.wb = 2'd1;
      end
      7'h23: begin ok = (f3 <= 3'd2); e.sl = f3; e.imm = 3'd2; e.bsel = 1; e.memw = 1; end
      7'h13: begin
        e.alu = (f3 == 3'd5 && ins[30]) ? 5'd9 : opTab[f3];
        e.imm = 3'd1; e.bsel = 1; e.rdw = 1;
      end
      7'h33: begin
        e.rdw = 1;
        if (f7 == 7'h00)                    e.alu = opTab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd9;
        else if (f7 == 7'h01 && mExt)       e.alu = 5'd11 + {2'b00, f3};
        else                                ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.rdw = 0; e.memw = 0; e.enbb = 0; e.enbj = 0;
    end
    e.illegal = !ok;
    return e;
  endfunction

  function automatic logic [31:0] genInstr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0:  w[6:0] = 7'h37;
      1:  w[6:0] = 7'h17;
      2:  w[6:0] = 7'h6F;
      3:  w[6:0] = 7'h67;
      4:  w[6:0] = 7'h63;
      5:  w[6:0] = 7'h03;
      6:  w[6:0] = 7'h23;
      7:  w[6:0] = 7'h13;
      8, 9: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0:       w[31:25] = 7'h00;
          1:       w[31:25] = 7'h20;
          2:       w[31:25] = 7'h01;
          default: ;
        endcase
      end
      10:      w = 32'h0000007F;
      default: ;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compareDut(input string pfx, input bit mExt, input obs_t o, input int expCnt);
    exp_t e;
    checkOutput({pfx, "o_vld"}, o.vld, pipeQ.size() > 0);
    checkOutput({pfx, "o_rdy"}, o.rdy, pipeQ.size() < 2);
    checkOutput({pfx, "cnt"}, o.cnt, expCnt);
    if (pipeQ.size() > 0) begin
      e = refDecode(pipeQ[0][31:0], mExt);
      checkOutput({pfx, "instr"}, o.instr, pipeQ[0][31:0]);
      checkOutput({pfx, "pc"}, o.pc, pipeQ[0][63:32]);
      checkOutput({pfx, "illegal"}, o.illegal, e.illegal);
      checkOutput({pfx, "insn_vld"}, o.insnv, !e.illegal);
      checkOutput({pfx, "rd_wren"}, o.rdw, e.rdw);
      checkOutput({pfx, "mem_wren"}, o.memw, e.memw);
      checkOutput({pfx, "enb_branch"}, o.enbb, e.enbb);
      checkOutput({pfx, "enb_jump"}, o.enbj, e.enbj);
      if (!e.illegal) begin
        checkOutput({pfx, "alu_op"}, o.alu, e.alu);
        checkOutput({pfx, "imm_sel"}, o.imm, e.imm);
        checkOutput({pfx, "slt_sl"}, o.sl, e.sl);
        checkOutput({pfx, "wb_sel"}, o.wb, e.wb);
        checkOutput({pfx, "op_a_sel"}, o.asel, e.asel);
        checkOutput({pfx, "op_b_sel"}, o.bsel, e.bsel);
        checkOutput({pfx, "br_unsigned"}, o.bru, e.bru);
        checkOutput({pfx, "br_funct3"}, o.bf3, e.bf3);
      end
    end
  endtask

  // One clock: drive inputs, advance the occupancy model at the edge, check at negedge.
  task automatic applyStimulus(input logic vld, input logic [31:0] ins, input logic [31:0] pcv,
                               input logic rdy, input logic fl, input logic rstn);
    logic [63:0] head;
    exp_t        e;
    bit          rdyNow;
    iVld = vld; iInstr = ins; iPc = pcv; iRdy = rdy; iFlush = fl; rstN = rstn;
    @(posedge clk);
    if (!rstn) begin
      pipeQ.delete();
      expCnt0 = 0;
      expCnt1 = 0;
    end else begin
      rdyNow = pipeQ.size() < 2;
      if (pipeQ.size() > 0 && rdy) begin
        head = pipeQ.pop_front();
        e = refDecode(head[31:0], 1'b0);
        if (e.illegal && expCnt0 < 3) expCnt0++;
        e = refDecode(head[31:0], 1'b1);
        if (e.illegal && expCnt1 < 255) expCnt1++;
      end
      if (fl) pipeQ.delete();
      else if (vld && rdyNow) pipeQ.push_back({pcv, ins});
    end
    @(negedge clk);
    compareDut("m0.", 1'b0, obs0, expCnt0);
    compareDut("m1.", 1'b1, obs1, expCnt1);
  endtask

  initial begin
    rstN = 1'b0; iVld = 1'b0; iRdy = 1'b0; iFlush = 1'b0; iInstr = '0; iPc = '0;
    expCnt0 = 0; expCnt1 = 0;
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
    // ADD then MUL, single accepts with a free downstream
    applyStimulus(1, 32'h002081B3, 32'h100, 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    applyStimulus(1, 32'h022081B3, 32'h104, 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    // LW, SW, BEQ with two stalled cycles
    applyStimulus(1, 32'h0000A183, 32'h200, 0, 0, 1);
    applyStimulus(1, 32'h0020A023, 32'h204, 0, 0, 1);
    applyStimulus(1, 32'h00208063, 32'h208, 1, 0, 1);
    applyStimulus(1, 32'h00208063, 32'h208, 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    // Flush with main and skid both occupied and a valid request present
    applyStimulus(1, 32'h002081B3, 32'h300, 0, 0, 1);
    applyStimulus(1, 32'h00208063, 32'h304, 0, 0, 1);
    applyStimulus(1, 32'h0000A183, 32'h308, 0, 1, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    // Five illegal opcodes saturate the 2-bit counter
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h0000007F, 32'h400 + 32'(4 * i), 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    // Reset in the middle of a stall
    applyStimulus(1, 32'h0020A023, 32'h500, 0, 0, 1);
    applyStimulus(1, 32'h00208063, 32'h504, 0, 0, 1);
    applyStimulus(1, 32'h002081B3, 32'h508, 0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, genInstr(), $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 99) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
